rsa_exp_ctrl: RTL and testbench

- Modular-exponentiation sequencer directly upstream of the Montgomery multiplier (mmm_unit).
- Computes C = P^E mod M by left-to-right square-and-multiply, issuing every Montgomery multiplication (MMM) to the unit.
- Drives the unit's control strobes and operand buses, reduces and stores each product, and reports the final result with a done pulse.

---
 rtl/rsa_pkg.sv | 40 ++++
 rtl/rsa_exp_ctrl_seq.sv | 92 +++++++++
 rtl/rsa_exp_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_rsa_exp_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and helpers for the modular-exponentiation sequencer.
// Optional build macro: RSA_SKIP_LZ_EN (leading-zero skipping, see rsa_exp_ctrl).
package rsa_pkg;

  // Top-level exponentiation schedule
  typedef enum logic [2:0] {
    IDLE,
    PRE_X,
    PRE_A,
    SQR,
    MUL,
    POST,
    FIN
  } state_t;

  // Per-multiplication sub-phases
  typedef enum logic [2:0] {
    CLR,
    LOAD,
    ITER,
    CAPT,
    WB
  } phase_t;

  // Cycles taken by one Montgomery multiplication: CLR + LOAD + WIDTH iterations + CAPT + WB
  function automatic int mmm_cycles(input int width);
    return width + 4;
  endfunction

  // Index of the highest set bit; 0 for a zero input (callers test for zero first)
  function automatic int msb_index(input logic [63:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rsa_exp_ctrl_seq.sv
// Phase sequencer for one Montgomery multiplication. A go pulse starts a
// CLR -> LOAD -> ITER x WIDTH -> CAPT -> WB run; the unit strobes are registered
// so they change exactly at phase boundaries. wb is high during the WB cycle.
module mmm_seq
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rstb,
  input  logic ena,
  input  logic go,
  output logic mmm_rst,
  output logic mmm_ld_a,
  output logic mmm_ld_r,
  output logic mmm_lock,
  output logic wb
);

  localparam int ITER_CYCLES = mmm_cycles(WIDTH) - 4;
  localparam int CW = $clog2(ITER_CYCLES + 1);

  phase_t phase_reg, phase_next;
  logic active_reg, active_next;
  logic [CW-1:0] iter_reg, iter_next;
  logic rst_reg, rst_next;
  logic lda_reg, lda_next;
  logic ldr_reg, ldr_next;
  logic lock_reg, lock_next;

  // Phase advance and strobe values for the coming cycle
  always_comb begin
    phase_next  = phase_reg;
    active_next = active_reg;
    iter_next   = iter_reg;
    if (go) begin
      phase_next  = CLR;
      active_next = 1'b1;
      iter_next   = '0;
    end else if (active_reg) begin
      case (phase_reg)
        CLR:  phase_next = LOAD;
        LOAD: begin
          phase_next = ITER;
          iter_next  = '0;
        end
        ITER: begin
          if (iter_reg == CW'(ITER_CYCLES - 1)) phase_next = CAPT;
          else iter_next = iter_reg + 1'b1;
        end
        CAPT: phase_next = WB;
        WB:   active_next = 1'b0;
        default: active_next = 1'b0;
      endcase
    end
    rst_next  = !(active_next && phase_next == CLR);
    lda_next  = active_next && phase_next == LOAD;
    ldr_next  = active_next && phase_next == CAPT;
    // lock is sticky from WB until the next multiplication clears the unit
    lock_next = lock_reg;
    if (active_next && phase_next == WB) lock_next = 1'b1;
    else if (active_next && phase_next == CLR) lock_next = 1'b0;
  end

  // Phase and strobe registers; frozen while ena is low
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      phase_reg  <= CLR;
      active_reg <= 1'b0;
      iter_reg   <= '0;
      rst_reg    <= 1'b0;
      lda_reg    <= 1'b0;
      ldr_reg    <= 1'b0;
      lock_reg   <= 1'b0;
    end else if (ena) begin
      phase_reg  <= phase_next;
      active_reg <= active_next;
      iter_reg   <= iter_next;
      rst_reg    <= rst_next;
      lda_reg    <= lda_next;
      ldr_reg    <= ldr_next;
      lock_reg   <= lock_next;
    end
  end

  assign mmm_rst  = rst_reg;
  assign mmm_ld_a = lda_reg;
  assign mmm_ld_r = ldr_reg;
  assign mmm_lock = lock_reg;
  assign wb       = active_reg && (phase_reg == WB);

endmodule

// File: rtl/rsa_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a Montgomery multiplier.
// Computes result = msg^expo mod modulus. Optional build macro RSA_SKIP_LZ_EN:
// skips PRE_A and the leading zeros of the exponent (data-dependent latency);
// without it the schedule is constant-time in the exponent's leading zeros.
module rsa_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] msg,
  input  logic [WIDTH-1:0] expo,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] r2,
  output logic             mmm_en,
  output logic             mmm_rst,
  output logic             mmm_ld_a,
  output logic             mmm_ld_r,
  output logic             mmm_lock,
  output logic [WIDTH-1:0] mmm_a,
  output logic [WIDTH-1:0] mmm_b,
  output logic [WIDTH-1:0] mmm_m,
  input  logic [WIDTH-1:0] mmm_r,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t state_reg, state_next;
  logic [WIDTH-1:0] msg_reg, expo_reg, mod_reg, r2_reg;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] xbar_reg, xbar_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [CW-1:0]    bit_reg, bit_next;
  logic             latch;
  logic             go;
  logic             wb;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] red;

  mmm_seq #(.WIDTH(WIDTH)) u_seq (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .go       (go),
    .mmm_rst  (mmm_rst),
    .mmm_ld_a (mmm_ld_a),
    .mmm_ld_r (mmm_ld_r),
    .mmm_lock (mmm_lock),
    .wb       (wb)
  );

  // Final conditional subtraction: the unit returns a value below 2M
  assign diff = {1'b0, mmm_r} - {1'b0, mod_reg};
  assign red  = diff[WIDTH] ? mmm_r : diff[WIDTH-1:0];

  // Operand selection; values only change at WB edges so they hold through CLR..CAPT
  always_comb begin
    mmm_a = '0;
    mmm_b = '0;
    mmm_m = (state_reg == IDLE) ? '0 : mod_reg;
    case (state_reg)
      PRE_X: begin mmm_a = msg_reg; mmm_b = r2_reg;   end
      PRE_A: begin mmm_a = ONE;     mmm_b = r2_reg;   end
      SQR:   begin mmm_a = acc_reg; mmm_b = acc_reg;  end
      MUL:   begin mmm_a = acc_reg; mmm_b = xbar_reg; end
      POST:  begin mmm_a = acc_reg; mmm_b = ONE;      end
      default: ;
    endcase
  end

  // Schedule: each state waits for its multiplication's WB cycle, stores the
  // reduced product and launches the next multiplication in the same cycle
  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    xbar_next   = xbar_reg;
    result_next = result_reg;
    bit_next    = bit_reg;
    latch       = 1'b0;
    go          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          latch      = 1'b1;
          go         = 1'b1;
          bit_next   = CW'(WIDTH - 1);
          state_next = PRE_X;
        end
      end
      PRE_X: begin
        if (wb) begin
          xbar_next = red;
          go        = 1'b1;
`ifdef RSA_SKIP_LZ_EN
          if (expo_reg == '0) begin
            state_next = PRE_A;
          end else begin
            // Montgomery form of msg already equals acc after the top 1 bit
            acc_next = red;
            if (msb_index(64'(expo_reg)) == 0) begin
              state_next = POST;
            end else begin
              bit_next   = CW'(msb_index(64'(expo_reg)) - 1);
              state_next = SQR;
            end
          end
`else
          state_next = PRE_A;
`endif
        end
      end
      PRE_A: begin
        if (wb) begin
          acc_next = red;
          go       = 1'b1;
`ifdef RSA_SKIP_LZ_EN
          state_next = POST;
`else
          state_next = SQR;
`endif
        end
      end
      SQR: begin
        if (wb) begin
          acc_next = red;
          go       = 1'b1;
          if (expo_reg[bit_reg]) begin
            state_next = MUL;
          end else if (bit_reg == '0) begin
            state_next = POST;
          end else begin
            bit_next   = bit_reg - 1'b1;
            state_next = SQR;
          end
        end
      end
      MUL: begin
        if (wb) begin
          acc_next = red;
          go       = 1'b1;
          if (bit_reg == '0) begin
            state_next = POST;
          end else begin
            bit_next   = bit_reg - 1'b1;
            state_next = SQR;
          end
        end
      end
      POST: begin
        if (wb) begin
          result_next = red;
          state_next  = FIN;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and latched-input registers; frozen while ena is low
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg  <= IDLE;
      msg_reg    <= '0;
      expo_reg   <= '0;
      mod_reg    <= '0;
      r2_reg     <= '0;
      acc_reg    <= '0;
      xbar_reg   <= '0;
      result_reg <= '0;
      bit_reg    <= '0;
    end else if (ena) begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      xbar_reg   <= xbar_next;
      result_reg <= result_next;
      bit_reg    <= bit_next;
      if (latch) begin
        msg_reg  <= msg;
        expo_reg <= expo;
        mod_reg  <= modulus;
        r2_reg   <= r2;
      end
    end
  end

  assign mmm_en = ena;
  assign busy   = (state_reg != IDLE) && (state_reg != FIN);
  assign done   = (state_reg == FIN);
  assign result = result_reg;

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Self-checking bench for rsa_exp_ctrl with a behavioural Montgomery unit stub.
// Honours RSA_SKIP_LZ_EN for expected latencies.
`timescale 1ns/1ps
module tb_rsa_exp_ctrl;

  localparam int W = 8;
  localparam int MOD = 187;
  localparam int R2C = 86;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         ena = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] msg = '0, expo = '0, modulus = '0, r2 = '0;
  logic         mmm_en, mmm_rst, mmm_ld_a, mmm_ld_r, mmm_lock;
  logic [W-1:0] mmm_a, mmm_b, mmm_m;
  logic [W-1:0] mmm_r = '0;
  logic         busy, done;
  logic [W-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rsa_exp_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .start(start),
    .msg(msg), .expo(expo), .modulus(modulus), .r2(r2),
    .mmm_en(mmm_en), .mmm_rst(mmm_rst), .mmm_ld_a(mmm_ld_a), .mmm_ld_r(mmm_ld_r),
    .mmm_lock(mmm_lock), .mmm_a(mmm_a), .mmm_b(mmm_b), .mmm_m(mmm_m),
    .mmm_r(mmm_r), .busy(busy), .done(done), .result(result)
  );

  // ---------------- models ----------------
  // Montgomery product a*b*2^-W mod m, left partially reduced (< 2^W)
  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] m);
    int x;
    x = int'(a) * int'(b);
    for (int i = 0; i < W; i++) begin
      if (x % 2 == 1) x = x + int'(m);
      x = x / 2;
    end
    if (x >= (1 << W)) x = x - int'(m);
    return W'(x);
  endfunction

  function automatic int model_modexp(input int p, input int e, input int m);
    int r;
    r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * p) % m;
    return r;
  endfunction

  function automatic int top_bit(input int e);
    int t;
    t = 0;
    for (int i = 0; i < W; i++) if (e[i]) t = i;
    return t;
  endfunction

  // Number of multiplications the schedule issues for exponent e
  function automatic int model_mmms(input int e);
`ifdef RSA_SKIP_LZ_EN
    if (e == 0) return 3;
    return 2 + top_bit(e) + $countones(e) - 1;
`else
    return W + $countones(e) + 3;
`endif
  endfunction

  function automatic int exp_lat(input int literal_lat, input int e);
`ifdef RSA_SKIP_LZ_EN
    return 1 + model_mmms(e) * (W + 4) + (literal_lat - (1 + (W + $countones(e) + 3) * (W + 4)));
`else
    return (e >= 0) ? literal_lat : 0;
`endif
  endfunction

  // Montgomery unit stub: product captured on ld_r; a protocol slip
  // (no clear before load, wrong iteration count, operands moving) corrupts it
  logic [W-1:0] la = '0, lb = '0, lm = '0;
  int  iter_cnt = 0;
  bit  cleared = 1'b0, ok_load = 1'b0;
  always @(posedge clk) begin
    if (mmm_en) begin
      if (!mmm_rst) cleared <= 1'b1;
      if (mmm_ld_a) begin
        la <= mmm_a; lb <= mmm_b; lm <= mmm_m;
        iter_cnt <= 0;
        ok_load <= cleared;
        cleared <= 1'b0;
      end else begin
        iter_cnt <= iter_cnt + 1;
      end
      if (mmm_ld_r && !mmm_lock) begin
        if (iter_cnt == W && ok_load && mmm_a == la && mmm_b == lb && mmm_m == lm)
          mmm_r <= mont(la, lb, lm);
        else
          mmm_r <= mont(la, lb, lm) ^ 8'h5A;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Cycle-by-cycle compare against the model: busy/done timing and final result
  task automatic monitor_loop();
    bit on;
    int cyc, exp_cyc, exp_res;
    on = 1'b0; cyc = 0; exp_cyc = 0; exp_res = 0;
    forever begin
      @(posedge clk);
      if (!rstb) begin
        on = 1'b0;
      end else if (ena) begin
        if (on) begin
          if (cyc == exp_cyc) on = 1'b0;
          else cyc++;
        end else if (start && !busy && !done) begin
          on      = 1'b1;
          cyc     = 1;
          exp_cyc = 1 + model_mmms(int'(expo)) * (W + 4);
          exp_res = model_modexp(int'(msg), int'(expo), int'(modulus));
        end
      end
      @(negedge clk);
      #2;
      if (rstb) begin
        chk("mon mmm_en", mmm_en, ena);
        if (on) begin
          chk("mon busy", busy, cyc < exp_cyc);
          chk("mon done", done, cyc == exp_cyc);
          if (cyc == exp_cyc) chk("mon result", result, exp_res);
        end else begin
          chk("mon idle busy", busy, 0);
          chk("mon idle done", done, 0);
        end
      end
    end
  endtask

  // evt: 0 none, 1 restart + input toggle at evt_cyc, 2 ena low for 20 cycles at evt_cyc
  task automatic run_case(input string name, input int p, input int e, input int exp_res,
                          input int lat, input int evt, input int evt_cyc);
    int cyc;
    msg = W'(p); expo = W'(e); modulus = W'(MOD); r2 = W'(R2C);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 3000) begin
      if (evt == 1 && cyc == evt_cyc) begin
        start = 1'b1; msg = 8'd5; expo = 8'd200; modulus = 8'd201; r2 = 8'd13;
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end else if (evt == 2 && cyc == evt_cyc) begin
        ena = 1'b0;
        repeat (20) @(negedge clk);
        ena = 1'b1;
        cyc += 20;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    $display("[TB] %s msg=%0d expo=%0d result=%0d latency=%0d", name, p, e, result, cyc);
    chk({name, " latency"}, cyc, lat);
    chk({name, " result"}, result, exp_res);
`ifdef RSA_SKIP_LZ_EN
    if (e == 7 && evt == 0) chk({name, " skip shorter"}, cyc < 169, 1);
`endif
    @(negedge clk);
  endtask

  task automatic main_seq();
    rstb = 1'b0; ena = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset mmm_rst", mmm_rst, 0);
    chk("reset ld_a", mmm_ld_a, 0);
    chk("reset ld_r", mmm_ld_r, 0);
    chk("reset lock", mmm_lock, 0);
    chk("reset mmm_a", mmm_a, 0);
    chk("reset mmm_b", mmm_b, 0);
    chk("reset result", result, 0);
    // pin the model with hand-computed values
    chk("model 88^7", model_modexp(88, 7, MOD), 11);
    chk("model 11^23", model_modexp(11, 23, MOD), 88);
    chk("model 1*R", mont(8'd1, 8'd86, 8'd187) % 187, 69);
    rstb = 1'b1;
    @(negedge clk);
    chk("idle mmm_rst", mmm_rst, 1);

    run_case("p88e7",  88, 7,  11, exp_lat(169, 7),  0, 0);
    run_case("p11e23", 11, 23, 88, exp_lat(181, 23), 0, 0);
    run_case("p88e0",  88, 0,  1,  exp_lat(133, 0),  0, 0);
    run_case("p88e1",  88, 1,  88, exp_lat(145, 1),  0, 0);
    run_case("restart", 88, 7, 11, exp_lat(169, 7),  1, 50);
    run_case("pause",   88, 7, 11, exp_lat(189, 7),  2, 40);

    // abort with reset at cycle 60
    msg = 8'd88; expo = 8'd7; modulus = W'(MOD); r2 = W'(R2C);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (59) @(negedge clk);
    rstb = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort mmm_rst", mmm_rst, 0);
    chk("abort ld_a", mmm_ld_a, 0);
    chk("abort ld_r", mmm_ld_r, 0);
    chk("abort lock", mmm_lock, 0);
    chk("abort mmm_m", mmm_m, 0);
    @(negedge clk);
    rstb = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort stays idle", busy, 0);
    run_case("after_reset", 88, 7, 11, exp_lat(169, 7), 0, 0);
  endtask

  initial begin
    fork
      monitor_loop();
      main_seq();
    join_any
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
